// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - shared MMIO offsets, CTRL bit indices and timer states for data_mem_responder
package dmem_pkg;

  localparam logic [7:0] OFF_CYCLE = 8'h00;
  localparam logic [7:0] OFF_LOAD  = 8'h04;
  localparam logic [7:0] OFF_CTRL  = 8'h08;
  localparam logic [7:0] OFF_STAT  = 8'h0C;
  localparam logic [7:0] OFF_GPIO  = 8'h10;
  localparam logic [7:0] OFF_COUNT = 8'h14;

  localparam int CTRL_ENABLE      = 0;
  localparam int CTRL_AUTO_RELOAD = 1;
  localparam int CTRL_IRQ_EN      = 2;

  typedef enum logic {T_IDLE, T_RUN} timer_state_e;

endpackage

// File: rtl/mmio_timer.sv
// rtl/mmio_timer.sv - down-counting timer with reload, sticky expiry flag and interrupt
module mmio_timer
  import dmem_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        we,
  input  logic [7:0]  off,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        timer_irq
);

  timer_state_e state, state_nxt;
  logic [31:0]  count, count_nxt;
  logic [31:0]  reload;
  logic [2:0]   ctrl;
  logic         expired, expired_nxt;
  logic         expire;
  logic         wr_load, wr_ctrl, wr_stat;

  assign wr_load = we && (off == OFF_LOAD);
  assign wr_ctrl = we && (off == OFF_CTRL);
  assign wr_stat = we && (off == OFF_STAT);

  // Next-state and count: hold in IDLE, decrement in RUN, expire on count==1; a LOAD write overrides count.
  always_comb begin
    state_nxt = state;
    count_nxt = count;
    expire    = 1'b0;
    case (state)
      T_IDLE: begin
        if (ctrl[CTRL_ENABLE] && (count != 32'd0)) state_nxt = T_RUN;
      end
      T_RUN: begin
        if (!ctrl[CTRL_ENABLE] || (count == 32'd0)) begin
          state_nxt = T_IDLE;
        end else if (count == 32'd1) begin
          expire = 1'b1;
          if (ctrl[CTRL_AUTO_RELOAD]) begin
            count_nxt = reload;
          end else begin
            count_nxt = 32'd0;
            state_nxt = T_IDLE;
          end
        end else begin
          count_nxt = count - 32'd1;
        end
      end
      default: state_nxt = T_IDLE;
    endcase
    if (wr_load) count_nxt = wdata;
    // Expiry set takes priority over a write-1-to-clear on the same edge.
    expired_nxt = expire | (expired & ~(wr_stat & wdata[0]));
  end

  // Timer registers with asynchronous abort on reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= T_IDLE;
      count   <= '0;
      reload  <= '0;
      ctrl    <= '0;
      expired <= 1'b0;
    end else begin
      state   <= state_nxt;
      count   <= count_nxt;
      expired <= expired_nxt;
      if (wr_load) reload <= wdata;
      if (wr_ctrl) ctrl <= wdata[2:0];
    end
  end

  // Readback of the timer's own offsets; everything else returns 0 for the top-level mux.
  always_comb begin
    rdata = '0;
    case (off)
      OFF_LOAD:  rdata = reload;
      OFF_CTRL:  rdata = {29'd0, ctrl};
      OFF_STAT:  rdata = {31'd0, expired};
      OFF_COUNT: rdata = count;
      default:   rdata = '0;
    endcase
  end

  assign timer_irq = expired & ctrl[CTRL_IRQ_EN];

endmodule

// File: rtl/data_mem_responder.sv
// rtl/data_mem_responder.sv - data RAM plus MMIO window (CYCLE, GPIO, timer when DMEM_TIMER_EN is defined)
module data_mem_responder
  import dmem_pkg::*;
#(
  parameter int          DEPTH_WORDS = 64,
  parameter logic [31:0] MMIO_BASE   = 32'hFFFF_FF00
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemWriteM,
  input  logic [31:0] ALUOutM,
  input  logic [31:0] WriteDataM,
  output logic [31:0] ReadDataM,
  output logic [7:0]  gpio_out,
  output logic        timer_irq
);

  localparam int IDX_W = $clog2(DEPTH_WORDS);

  logic [31:0]      mem [DEPTH_WORDS];
  logic [31:0]      cycle;
  logic [7:0]       gpio;
  logic             is_mmio;
  logic [7:0]       off;
  logic [IDX_W-1:0] idx;
  logic             ram_we, mmio_we;
  logic [31:0]      timer_rdata;
  logic [31:0]      mmio_rdata;

  assign is_mmio = (ALUOutM >= MMIO_BASE);
  assign off     = {ALUOutM[7:2], 2'b00};
  assign idx     = ALUOutM[IDX_W+1:2];
  assign ram_we  = MemWriteM && !is_mmio;
  assign mmio_we = MemWriteM && is_mmio;

  // Word RAM: no reset, write on the edge, upper address bits alias.
  always_ff @(posedge clk) begin
    if (ram_we) mem[idx] <= WriteDataM;
  end

  // Free-running cycle counter and GPIO output register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cycle <= '0;
      gpio  <= '0;
    end else begin
      cycle <= cycle + 32'd1;
      if (mmio_we && (off == OFF_GPIO)) gpio <= WriteDataM[7:0];
    end
  end

`ifdef DMEM_TIMER_EN
  mmio_timer u_timer (
    .clk       (clk),
    .rst_n     (reset),
    .we        (mmio_we),
    .off       (off),
    .wdata     (WriteDataM),
    .rdata     (timer_rdata),
    .timer_irq (timer_irq)
  );
`else
  assign timer_rdata = '0;
  assign timer_irq   = 1'b0;
`endif

  // MMIO readback mux; timer offsets (or unmapped ones) come from timer_rdata.
  always_comb begin
    mmio_rdata = '0;
    case (off)
      OFF_CYCLE: mmio_rdata = cycle;
      OFF_GPIO:  mmio_rdata = {24'd0, gpio};
      default:   mmio_rdata = timer_rdata;
    endcase
  end

  assign ReadDataM = !reset ? 32'd0 : (is_mmio ? mmio_rdata : mem[idx]);
  assign gpio_out  = gpio;

endmodule
